lsu_axi_master: RTL and testbench

//  Load/store bridge between the core's memory stage and the AXI-lite data RAM slave.
//  It accepts one byte/half/word request at a time and drives the AR/R and AW/W channels.

---
 rtl/lsu_axi_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi_master
//  Description : Load/store bridge from the core memory stage to an AXI-lite
//                data RAM slave. One byte/half/word request at a time; loads
//                are lane-extracted and extended, sub-word stores are done as
//                read-modify-write because the slave has no write strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,          // asynchronous, active low
    // core request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    // AXI-lite read channels
    output logic [29:0]           ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY,
    // AXI-lite write channels
    output logic [29:0]           AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_MERGE = 3'd3,
        S_AWW   = 3'd4,
        S_WHOLD = 3'd5,
        S_RESP  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [31:0]             cap_addr;
    logic [1:0]              cap_size;
    logic                    cap_we;
    logic                    cap_unsigned;
    logic [DATA_WIDTH-1:0]   cap_wdata;     // store data, later the merged write word
    logic [DATA_WIDTH-1:0]   cap_rdata;     // word returned on R
    logic [7:0]              timer;
    logic                    aw_done;
    logic                    w_done;

    logic                    accept;
    logic                    bad_req;
    logic                    waiting;
    logic                    timed_out;
    logic                    aw_fire;
    logic                    w_fire;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   shifted;

    assign accept    = req_valid & req_ready;
    assign bad_req   = (req_size == 2'd3)
                     | ((req_size == 2'd1) & req_addr[0])
                     | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    assign timed_out = ((timer + 8'd1) == TIMEOUT_LIMIT);

    // Address and write data come straight from capture registers so they
    // stay stable for as long as the corresponding valid is asserted.
    assign ARADDR = cap_addr[31:2];
    assign AWADDR = cap_addr[31:2];
    assign WDATA  = cap_wdata;

    // Load lane extraction with sign/zero extension
    always_comb begin
        shifted  = cap_rdata >> {cap_addr[1:0], 3'b000};
        load_ext = cap_rdata;
        if (cap_size == 2'd0) begin
            load_ext = {{24{shifted[7] & ~cap_unsigned}}, shifted[7:0]};
        end else if (cap_size == 2'd1) begin
            load_ext = cap_addr[1]
                     ? {{16{cap_rdata[31] & ~cap_unsigned}}, cap_rdata[31:16]}
                     : {{16{cap_rdata[15] & ~cap_unsigned}}, cap_rdata[15:0]};
        end
    end

    // Sub-word store merge: new lane over the word read back from the slave
    always_comb begin
        merged = cap_rdata;
        if (cap_size == 2'd0) begin
            merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        end else begin
            merged[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
        end
    end

    // Next-state logic and channel/response outputs
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        waiting    = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = rst;
                if (req_valid) begin
                    if (bad_req) begin
                        next_state = S_ERR;
                    end else if (req_we && (req_size == 2'd2)) begin
                        next_state = S_AWW;
                    end else begin
                        next_state = S_AR;
                    end
                end
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    next_state = S_R;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) next_state = S_ERR;
                end
            end
            S_R: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    next_state = cap_we ? S_MERGE : S_RESP;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) next_state = S_ERR;
                end
            end
            S_MERGE: begin
                next_state = S_AWW;
            end
            S_AWW: begin
                AWVALID = ~aw_done;
                WVALID  = ~w_done;
                aw_fire = AWVALID & AWREADY;
                w_fire  = WVALID & WREADY;
                if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                    next_state = S_WHOLD;
                end else begin
                    waiting = 1'b1;
                    if (timed_out) next_state = S_ERR;
                end
            end
            S_WHOLD: begin
                next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = cap_we ? '0 : load_ext;
                next_state = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Handshake timer: restarts on every state change, counts waiting cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     timer <= 8'd0;
        else if (next_state != state) timer <= 8'd0;
        else if (waiting)             timer <= timer + 8'd1;
    end

    // Per-channel completion flags for the joint AW/W phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == S_AWW) begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // Request capture, read-data capture and store-word merge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr     <= '0;
            cap_size     <= '0;
            cap_we       <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            cap_rdata    <= '0;
        end else begin
            if (accept) begin
                cap_addr     <= req_addr;
                cap_size     <= req_size;
                cap_we       <= req_we;
                cap_unsigned <= req_unsigned;
                cap_wdata    <= req_wdata;
            end
            if ((state == S_R) && RVALID) cap_rdata <= RDATA;
            if (state == S_MERGE)         cap_wdata <= merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_axi_master
//  Description : Directed self-checking bench for lsu_axi_master with a small
//                behavioural AXI-lite RAM slave and channel activity monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic [29:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;

    // slave knobs
    logic        ar_en = 1'b1;
    logic        r_en  = 1'b1;
    int          aw_delay = 0;

    // slave state
    logic [31:0] mem [16];
    logic        r_pend;
    logic [31:0] s_rdata;
    int          aw_wait;
    logic        aw_got, w_got;
    logic [29:0] s_awaddr;
    logic [31:0] s_wdata;

    // monitor totals
    int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic [29:0] last_araddr = '0, last_awaddr = '0;
    logic [31:0] last_wdata = '0;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] res_rdata;
    logic        res_err;
    int          res_lat;

    lsu_axi_master #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RDATA        (RDATA),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WVALID       (WVALID),
        .WREADY       (WREADY)
    );

    always #5 clk = ~clk;

    assign ARREADY = ar_en;
    assign RVALID  = r_pend & r_en;
    assign RDATA   = s_rdata;
    assign AWREADY = AWVALID && (aw_wait >= aw_delay);
    assign WREADY  = 1'b1;

    // Behavioural RAM slave; commits once both AW and W have been seen
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'h8765_43A1;
            mem[5]   <= 32'h1122_3344;
            r_pend   <= 1'b0;
            s_rdata  <= 32'h0;
            aw_wait  <= 0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            s_awaddr <= '0;
            s_wdata  <= '0;
        end else begin
            if (ARVALID && ARREADY) begin
                r_pend  <= 1'b1;
                s_rdata <= mem[ARADDR[3:0]];
            end else if (RVALID && RREADY) begin
                r_pend <= 1'b0;
            end
            if (AWVALID && !AWREADY) aw_wait <= aw_wait + 1;
            else                     aw_wait <= 0;
            if (aw_got && w_got) begin
                mem[s_awaddr[3:0]] <= s_wdata;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (AWVALID && AWREADY) begin aw_got <= 1'b1; s_awaddr <= AWADDR; end
                if (WVALID && WREADY)   begin w_got  <= 1'b1; s_wdata  <= WDATA;  end
            end
        end
    end

    // Channel activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ARVALID) ar_cyc <= ar_cyc + 1;
        if (AWVALID) aw_cyc <= aw_cyc + 1;
        if (WVALID)  w_cyc  <= w_cyc + 1;
        if (ARVALID && ARREADY) last_araddr <= ARADDR;
        if (AWVALID && AWREADY) last_awaddr <= AWADDR;
        if (WVALID && WREADY)   last_wdata  <= WDATA;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE; latency counts the accept cycle as 1
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = size; req_unsigned = uns; req_wdata = wdata;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        res_lat = 2;
        while (!resp_valid && res_lat < 600) begin
            @(negedge clk);
            res_lat++;
        end
        if (!resp_valid) chk("resp_bound", 32'd0, 32'd1);
        res_rdata = resp_rdata;
        res_err   = resp_err;
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    int  ar0, aw0, w0;
    logic seen;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valids", {27'd0, resp_valid, ARVALID, RREADY, AWVALID, WVALID}, 32'd0);
        rst = 1'b1;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // 1: word load
        ar0 = ar_cyc;
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("lw_data", res_rdata, 32'h8765_43A1);
        chk("lw_err", {31'd0, res_err}, 32'd0);
        chk("lw_lat", res_lat, 32'd4);
        chk("lw_araddr", {2'b0, last_araddr}, 32'd4);
        chk("lw_ar_cycles", ar_cyc - ar0, 32'd1);

        // 2: sub-word loads
        run_req(1'b0, 32'h10, 2'd0, 1'b0, 32'h0); chk("lb_10",  res_rdata, 32'hFFFF_FFA1);
        run_req(1'b0, 32'h10, 2'd0, 1'b1, 32'h0); chk("lbu_10", res_rdata, 32'h0000_00A1);
        run_req(1'b0, 32'h12, 2'd1, 1'b0, 32'h0); chk("lh_12",  res_rdata, 32'hFFFF_8765);
        run_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0); chk("lhu_12", res_rdata, 32'h0000_8765);
        run_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0); chk("lb_13",  res_rdata, 32'hFFFF_FF87);
        run_req(1'b0, 32'h11, 2'd0, 1'b0, 32'h0); chk("lb_11",  res_rdata, 32'h0000_0043);
        run_req(1'b0, 32'h10, 2'd1, 1'b0, 32'h0); chk("lh_10",  res_rdata, 32'h0000_43A1);

        // 3: sub-word stores (read-modify-write)
        ar0 = ar_cyc;
        run_req(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFF_FF5C);
        chk("sb_err", {31'd0, res_err}, 32'd0);
        chk("sb_rdata", res_rdata, 32'h0);
        chk("sb_wdata", last_wdata, 32'h8765_5CA1);
        chk("sb_awaddr", {2'b0, last_awaddr}, 32'd4);
        chk("sb_lat", res_lat, 32'd7);
        chk("sb_ar_cycles", ar_cyc - ar0, 32'd1);
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0); chk("sb_readback", res_rdata, 32'h8765_5CA1);
        run_req(1'b1, 32'h16, 2'd1, 1'b0, 32'h0000_BEEF);
        chk("sh_wdata", last_wdata, 32'hBEEF_3344);
        run_req(1'b0, 32'h14, 2'd2, 1'b0, 32'h0); chk("sh_readback", res_rdata, 32'hBEEF_3344);

        // word store: no read phase
        ar0 = ar_cyc;
        run_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF);
        chk("sw_lat", res_lat, 32'd4);
        chk("sw_ar_cycles", ar_cyc - ar0, 32'd0);
        chk("sw_awaddr", {2'b0, last_awaddr}, 32'd8);
        run_req(1'b0, 32'h20, 2'd2, 1'b0, 32'h0); chk("sw_readback", res_rdata, 32'hDEAD_BEEF);

        // 4: misaligned and illegal size
        ar0 = ar_cyc; aw0 = aw_cyc; w0 = w_cyc;
        run_req(1'b1, 32'h13, 2'd1, 1'b0, 32'h1234);
        chk("sh13_err", {31'd0, res_err}, 32'd1);
        chk("sh13_lat", res_lat, 32'd2);
        run_req(1'b0, 32'h12, 2'd2, 1'b0, 32'h0);
        chk("lw12_err", {31'd0, res_err}, 32'd1);
        chk("lw12_rdata", res_rdata, 32'h0);
        run_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
        chk("size3_err", {31'd0, res_err}, 32'd1);
        chk("err_no_channels", (ar_cyc - ar0) + (aw_cyc - aw0) + (w_cyc - w0), 32'd0);

        // 5: AWREADY three cycles late, WREADY immediate
        aw0 = aw_cyc; w0 = w_cyc;
        aw_delay = 3;
        run_req(1'b1, 32'h24, 2'd2, 1'b0, 32'h0BAD_F00D);
        aw_delay = 0;
        chk("awdly_err", {31'd0, res_err}, 32'd0);
        chk("awdly_w_cycles", w_cyc - w0, 32'd1);
        chk("awdly_aw_cycles", aw_cyc - aw0, 32'd4);
        chk("awdly_lat", res_lat, 32'd7);
        run_req(1'b0, 32'h24, 2'd2, 1'b0, 32'h0); chk("awdly_readback", res_rdata, 32'h0BAD_F00D);

        // 6a: AR timeout
        ar0 = ar_cyc;
        ar_en = 1'b0;
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        ar_en = 1'b1;
        chk("to_err", {31'd0, res_err}, 32'd1);
        chk("to_rdata", res_rdata, 32'h0);
        chk("to_ar_cycles", ar_cyc - ar0, 32'd255);
        chk("to_lat", res_lat, 32'd257);

        // 6b: reset while waiting in R
        r_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("in_r_rready", {31'd0, RREADY}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valids", {27'd0, resp_valid, ARVALID, RREADY, AWVALID, WVALID}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_araddr", {2'b0, ARADDR}, 32'd0);
        chk("mid_rst_rdata", resp_rdata, 32'd0);
        r_en = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen = seen | resp_valid; end
        rst = 1'b1;
        repeat (4) begin @(negedge clk); seen = seen | resp_valid | RREADY; end
        chk("rst_no_resp", {31'd0, seen}, 32'd0);
        chk("rst_idle_ready", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("post_rst_lw", res_rdata, 32'h8765_43A1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute run-time guard
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
